trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// trap_ctrl: machine/supervisor trap entry and xRET return control.
// It holds the trap CSRs and the current privilege level, and it drives a
// fetch redirect with a pipeline flush until fetch accepts the new PC.
module trap_ctrl #(
  parameter logic [63:0] MTVEC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc,
  input  logic [63:0] exc_cause,
  input  logic [63:0] exc_val,
  input  logic [63:0] exc_pc,
  input  logic        mret,
  input  logic        sret,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [63:0] csr_wdata,
  output logic [63:0] csr_rdata,
  output logic [1:0]  priv,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        flush_all
);

  typedef enum logic [0:0] {IDLE = 1'b0, REDIRECT = 1'b1} state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEDELEG = 12'h302;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_STVEC   = 12'h105;
  localparam logic [11:0] CSR_SEPC    = 12'h141;
  localparam logic [11:0] CSR_SCAUSE  = 12'h142;
  localparam logic [11:0] CSR_STVAL   = 12'h143;

  // Bit 11 of medeleg (ecall from M) can never be delegated.
  localparam logic [63:0] MEDELEG_MASK = 64'hFFFF_FFFF_FFFF_F7FF;

  state_e      state_q, state_d;
  logic [1:0]  priv_q, priv_d;
  logic        sie_q, sie_d, mie_q, mie_d, spie_q, spie_d, mpie_q, mpie_d;
  logic        spp_q, spp_d;
  logic [1:0]  mpp_q, mpp_d;
  logic [63:0] medeleg_q, medeleg_d, mtvec_q, mtvec_d, stvec_q, stvec_d;
  logic [63:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [63:0] sepc_q, sepc_d, scause_q, scause_d, stval_q, stval_d;
  logic [63:0] target_q, target_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic        flush_all_q, flush_all_d;
  logic [63:0] mstatus_s;
  logic        delegate_s;

  assign priv           = priv_q;
  assign redirect_valid = redirect_valid_q;
  assign flush_all      = flush_all_q;
  assign redirect_pc    = target_q;

  // Assemble the visible mstatus view; unimplemented bits read as zero.
  always_comb begin
    mstatus_s = {51'd0, mpp_q, 2'b00, spp_q, mpie_q, 1'b0, spie_q, 1'b0,
                 mie_q, 1'b0, sie_q, 1'b0};
  end

  // Combinational CSR read port; unmapped addresses return zero.
  always_comb begin
    case (csr_addr)
      CSR_MSTATUS: csr_rdata = mstatus_s;
      CSR_MEDELEG: csr_rdata = medeleg_q;
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      CSR_MTVAL:   csr_rdata = mtval_q;
      CSR_STVEC:   csr_rdata = stvec_q;
      CSR_SEPC:    csr_rdata = sepc_q;
      CSR_SCAUSE:  csr_rdata = scause_q;
      CSR_STVAL:   csr_rdata = stval_q;
      default:     csr_rdata = 64'd0;
    endcase
  end

  // Synchronous exceptions below 64 are delegated to S when not already in M.
  always_comb begin
    delegate_s = (priv_q != 2'b11) && !exc_cause[63] &&
                 (exc_cause[62:6] == 57'd0) && medeleg_q[exc_cause[5:0]];
  end

  // Next-state logic: trap entry, xRET, CSR writes and redirect handshake.
  always_comb begin
    state_d   = state_q;   priv_d    = priv_q;
    sie_d     = sie_q;     mie_d     = mie_q;
    spie_d    = spie_q;    mpie_d    = mpie_q;
    spp_d     = spp_q;     mpp_d     = mpp_q;
    medeleg_d = medeleg_q; mtvec_d   = mtvec_q;   stvec_d  = stvec_q;
    mepc_d    = mepc_q;    mcause_d  = mcause_q;  mtval_d  = mtval_q;
    sepc_d    = sepc_q;    scause_d  = scause_q;  stval_d  = stval_q;
    target_d  = target_q;
    case (state_q)
      IDLE: begin
        if (exc) begin
          state_d = REDIRECT;
          if (delegate_s) begin
            sepc_d   = {exc_pc[63:1], 1'b0};
            scause_d = exc_cause;
            stval_d  = exc_val;
            spie_d   = sie_q;
            sie_d    = 1'b0;
            spp_d    = priv_q[0];
            priv_d   = 2'b01;
            target_d = {stvec_q[63:2], 2'b00};
          end else begin
            mepc_d   = {exc_pc[63:1], 1'b0};
            mcause_d = exc_cause;
            mtval_d  = exc_val;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            mpp_d    = priv_q;
            priv_d   = 2'b11;
            target_d = {mtvec_q[63:2], 2'b00};
          end
        end else if (mret && (priv_q == 2'b11)) begin
          state_d  = REDIRECT;
          priv_d   = mpp_q;
          mie_d    = mpie_q;
          mpie_d   = 1'b1;
          mpp_d    = 2'b00;
          target_d = mepc_q;
        end else if (sret && (priv_q != 2'b00)) begin
          state_d  = REDIRECT;
          priv_d   = {1'b0, spp_q};
          sie_d    = spie_q;
          spie_d   = 1'b1;
          spp_d    = 1'b0;
          target_d = sepc_q;
        end else if (csr_we) begin
          case (csr_addr)
            CSR_MSTATUS: begin
              sie_d  = csr_wdata[1];
              mie_d  = csr_wdata[3];
              spie_d = csr_wdata[5];
              mpie_d = csr_wdata[7];
              spp_d  = csr_wdata[8];
              mpp_d  = (csr_wdata[12:11] == 2'b10) ? 2'b00 : csr_wdata[12:11];
            end
            CSR_MEDELEG: medeleg_d = csr_wdata & MEDELEG_MASK;
            CSR_MTVEC:   mtvec_d   = csr_wdata;
            CSR_MEPC:    mepc_d    = {csr_wdata[63:1], 1'b0};
            CSR_MCAUSE:  mcause_d  = csr_wdata;
            CSR_MTVAL:   mtval_d   = csr_wdata;
            CSR_STVEC:   stvec_d   = csr_wdata;
            CSR_SEPC:    sepc_d    = {csr_wdata[63:1], 1'b0};
            CSR_SCAUSE:  scause_d  = csr_wdata;
            CSR_STVAL:   stval_d   = csr_wdata;
            default:     mtvec_d   = mtvec_q;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end else begin
          state_d = REDIRECT;
        end
      end
      default: state_d = IDLE;
    endcase
    redirect_valid_d = (state_d == REDIRECT);
    flush_all_d      = (state_d == REDIRECT);
  end

  // State, CSR and registered-output flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;      priv_q    <= 2'b11;
      sie_q     <= 1'b0;      mie_q     <= 1'b0;
      spie_q    <= 1'b0;      mpie_q    <= 1'b0;
      spp_q     <= 1'b0;      mpp_q     <= 2'b00;
      medeleg_q <= 64'd0;     mtvec_q   <= MTVEC_RESET; stvec_q <= 64'd0;
      mepc_q    <= 64'd0;     mcause_q  <= 64'd0;       mtval_q <= 64'd0;
      sepc_q    <= 64'd0;     scause_q  <= 64'd0;       stval_q <= 64'd0;
      target_q  <= 64'd0;
      redirect_valid_q <= 1'b0;
      flush_all_q      <= 1'b0;
    end else begin
      state_q   <= state_d;   priv_q    <= priv_d;
      sie_q     <= sie_d;     mie_q     <= mie_d;
      spie_q    <= spie_d;    mpie_q    <= mpie_d;
      spp_q     <= spp_d;     mpp_q     <= mpp_d;
      medeleg_q <= medeleg_d; mtvec_q   <= mtvec_d;     stvec_q <= stvec_d;
      mepc_q    <= mepc_d;    mcause_q  <= mcause_d;    mtval_q <= mtval_d;
      sepc_q    <= sepc_d;    scause_q  <= scause_d;    stval_q <= stval_d;
      target_q  <= target_d;
      redirect_valid_q <= redirect_valid_d;
      flush_all_q      <= flush_all_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed scenarios plus randomized traffic for trap_ctrl,
// every cycle compared against a word-level reference model of the CSRs.
module tb_trap_ctrl;

  localparam logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000;
  localparam logic [63:0] MS_MASK   = 64'h0000_0000_0000_19AA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc = 1'b0;
  logic [63:0] exc_cause = 64'd0, exc_val = 64'd0, exc_pc = 64'd0;
  logic        mret = 1'b0, sret = 1'b0, csr_we = 1'b0;
  logic [11:0] csr_addr = 12'd0;
  logic [63:0] csr_wdata = 64'd0;
  logic [63:0] csr_rdata;
  logic [1:0]  priv;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic        flush_all;

  int n_checks = 0;
  int n_fail   = 0;

  trap_ctrl #(.MTVEC_RESET(MTVEC_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .exc(exc), .exc_cause(exc_cause), .exc_val(exc_val), .exc_pc(exc_pc),
    .mret(mret), .sret(sret),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .priv(priv),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .flush_all(flush_all)
  );

  always #5 clk = ~clk;

  // Reference model: mstatus kept as a masked word, CSRs as plain words.
  logic        m_busy;
  logic [1:0]  m_priv;
  logic [63:0] m_ms, m_medeleg, m_mtvec, m_stvec, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_sepc, m_scause, m_stval, m_target;

  function automatic logic [63:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_ms;
      12'h302: return m_medeleg;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h105: return m_stvec;
      12'h141: return m_sepc;
      12'h142: return m_scause;
      12'h143: return m_stval;
      default: return 64'd0;
    endcase
  endfunction

  function automatic void m_write(input logic [11:0] a, input logic [63:0] w);
    case (a)
      12'h300: begin
        m_ms = w & MS_MASK;
        if (m_ms[12:11] == 2'b10) m_ms[12] = 1'b0;
      end
      12'h302: m_medeleg = w & ~(64'd1 << 11);
      12'h305: m_mtvec   = w;
      12'h341: m_mepc    = w & ~64'd1;
      12'h342: m_mcause  = w;
      12'h343: m_mtval   = w;
      12'h105: m_stvec   = w;
      12'h141: m_sepc    = w & ~64'd1;
      12'h142: m_scause  = w;
      12'h143: m_stval   = w;
      default: ;
    endcase
  endfunction

  function automatic void model_step();
    logic [1:0] old_priv;
    old_priv = m_priv;
    if (!rst_n) begin
      m_busy = 1'b0; m_priv = 2'd3; m_ms = 64'd0; m_medeleg = 64'd0;
      m_mtvec = MTVEC_RST; m_stvec = 64'd0; m_mepc = 64'd0; m_mcause = 64'd0;
      m_mtval = 64'd0; m_sepc = 64'd0; m_scause = 64'd0; m_stval = 64'd0;
      m_target = 64'd0;
    end else if (m_busy) begin
      if (redirect_ready) m_busy = 1'b0;
    end else if (exc) begin
      m_busy = 1'b1;
      if (old_priv != 2'd3 && exc_cause < 64 && m_medeleg[exc_cause[5:0]]) begin
        m_sepc = exc_pc & ~64'd1; m_scause = exc_cause; m_stval = exc_val;
        m_ms[5] = m_ms[1]; m_ms[1] = 1'b0; m_ms[8] = old_priv[0];
        m_priv = 2'd1; m_target = m_stvec & ~64'd3;
      end else begin
        m_mepc = exc_pc & ~64'd1; m_mcause = exc_cause; m_mtval = exc_val;
        m_ms[7] = m_ms[3]; m_ms[3] = 1'b0; m_ms[12:11] = old_priv;
        m_priv = 2'd3; m_target = m_mtvec & ~64'd3;
      end
    end else if (mret && old_priv == 2'd3) begin
      m_busy = 1'b1; m_priv = m_ms[12:11]; m_ms[3] = m_ms[7]; m_ms[7] = 1'b1;
      m_ms[12:11] = 2'd0; m_target = m_mepc;
    end else if (sret && old_priv != 2'd0) begin
      m_busy = 1'b1; m_priv = {1'b0, m_ms[8]}; m_ms[1] = m_ms[5]; m_ms[5] = 1'b1;
      m_ms[8] = 1'b0; m_target = m_sepc;
    end else if (csr_we) begin
      m_write(csr_addr, csr_wdata);
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock: model evaluated on the inputs, DUT sampled 1ns after the edge.
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    check("redirect_valid", {63'd0, redirect_valid}, {63'd0, m_busy});
    check("flush_all", {63'd0, flush_all}, {63'd0, m_busy});
    check("redirect_pc", redirect_pc, m_target);
    check("priv", {62'd0, priv}, {62'd0, m_priv});
    check("csr_rdata", csr_rdata, m_read(csr_addr));
  endtask

  task automatic quiet();
    exc = 1'b0; mret = 1'b0; sret = 1'b0; csr_we = 1'b0; redirect_ready = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [63:0] w);
    quiet(); csr_we = 1'b1; csr_addr = a; csr_wdata = w; cycle(); quiet();
  endtask

  task automatic trap(input logic [63:0] c, input logic [63:0] pc, input logic [11:0] ra);
    quiet(); exc = 1'b1; exc_cause = c; exc_pc = pc; exc_val = 64'd0;
    csr_addr = ra; cycle(); quiet();
  endtask

  task automatic accept(input logic [11:0] ra);
    quiet(); redirect_ready = 1'b1; csr_addr = ra; cycle(); quiet();
  endtask

  logic [11:0] addrs [10] = '{12'h300, 12'h302, 12'h305, 12'h341, 12'h342,
                              12'h343, 12'h105, 12'h141, 12'h142, 12'h143};
  logic [63:0] pc_hold;

  initial begin
    // Reset state.
    rst_n = 1'b0; csr_addr = 12'h305; cycle();
    check("rst_priv", {62'd0, priv}, 64'd3);
    check("rst_mtvec", csr_rdata, MTVEC_RST);
    check("rst_valid", {63'd0, redirect_valid}, 64'd0);
    quiet(); csr_addr = 12'h300; cycle();
    check("rst_mstatus", csr_rdata, 64'd0);

    // M-mode trap entry.
    wr(12'h305, 64'h8000_0100);
    trap(64'd2, 64'h8000_0040, 12'h341);
    check("mtrap_valid", {63'd0, redirect_valid}, 64'd1);
    check("mtrap_pc", redirect_pc, 64'h8000_0100);
    check("mtrap_mepc", csr_rdata, 64'h8000_0040);
    csr_addr = 12'h342; cycle();
    check("mtrap_mcause", csr_rdata, 64'd2);
    accept(12'h300);
    check("mtrap_mpp", {62'd0, csr_rdata[12:11]}, 64'd3);
    check("mtrap_mie", {63'd0, csr_rdata[3]}, 64'd0);
    check("mtrap_done", {63'd0, redirect_valid}, 64'd0);

    // Drop to U with mret, then a delegated trap to S.
    wr(12'h300, 64'd0);
    wr(12'h341, 64'h8000_0000);
    quiet(); mret = 1'b1; cycle(); accept(12'h300);
    check("to_user", {62'd0, priv}, 64'd0);
    wr(12'h302, 64'h100);
    wr(12'h105, 64'h8020_0000);
    trap(64'd8, 64'h8000_1234, 12'h141);
    check("strap_priv", {62'd0, priv}, 64'd1);
    check("strap_pc", redirect_pc, 64'h8020_0000);
    check("strap_sepc", csr_rdata, 64'h8000_1234);
    csr_addr = 12'h142; cycle();
    check("strap_scause", csr_rdata, 64'd8);
    accept(12'h300);
    check("strap_spp", {63'd0, csr_rdata[8]}, 64'd0);
    // Non-delegated cause from S goes to M, then cause 8 from M stays in M.
    trap(64'd2, 64'h8020_0010, 12'h342); accept(12'h342);
    check("s_to_m", {62'd0, priv}, 64'd3);
    trap(64'd8, 64'h8000_2000, 12'h342);
    check("m_nodeleg_priv", {62'd0, priv}, 64'd3);
    check("m_nodeleg_pc", redirect_pc, 64'h8000_0100);
    check("m_nodeleg_cause", csr_rdata, 64'd8);
    accept(12'h300);

    // mret restoring MPIE and MPP.
    wr(12'h300, 64'h80);
    wr(12'h341, 64'h8000_1000);
    quiet(); mret = 1'b1; csr_addr = 12'h300; cycle(); quiet();
    check("mret_priv", {62'd0, priv}, 64'd0);
    check("mret_pc", redirect_pc, 64'h8000_1000);
    check("mret_mie", {63'd0, csr_rdata[3]}, 64'd1);
    check("mret_mpie", {63'd0, csr_rdata[7]}, 64'd1);
    check("mret_mpp", {62'd0, csr_rdata[12:11]}, 64'd0);
    accept(12'h300);

    // Trap wins over mret and CSR write; redirect held for 4 cycles.
    quiet(); exc = 1'b1; exc_cause = 64'd2; exc_pc = 64'h8000_3000;
    mret = 1'b1; csr_we = 1'b1; csr_addr = 12'h305; csr_wdata = 64'h1234;
    cycle(); quiet();
    check("prio_valid", {63'd0, redirect_valid}, 64'd1);
    pc_hold = redirect_pc;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("hold_valid", {63'd0, redirect_valid}, 64'd1);
      check("hold_flush", {63'd0, flush_all}, 64'd1);
      check("hold_pc", redirect_pc, pc_hold);
    end
    accept(12'h305);
    check("prio_mtvec", csr_rdata, 64'h8000_0100);
    check("prio_released", {63'd0, redirect_valid}, 64'd0);

    // CSR write legalisation.
    wr(12'h300, 64'h1000);
    check("mpp_legal", {62'd0, csr_rdata[12:11]}, 64'd0);
    wr(12'h302, 64'hFFFF_FFFF_FFFF_FFFF);
    check("medeleg_b11", csr_rdata, 64'hFFFF_FFFF_FFFF_F7FF);
    wr(12'h341, 64'h8000_1003);
    check("mepc_b0", csr_rdata, 64'h8000_1002);
    wr(12'h7C0, 64'hDEAD);
    check("unmapped", csr_rdata, 64'd0);

    // Reset during REDIRECT.
    wr(12'h305, 64'h8000_4000);
    trap(64'd3, 64'h8000_5000, 12'h305);
    rst_n = 1'b0; cycle(); quiet();
    check("rstr_valid", {63'd0, redirect_valid}, 64'd0);
    check("rstr_flush", {63'd0, flush_all}, 64'd0);
    check("rstr_priv", {62'd0, priv}, 64'd3);
    check("rstr_mtvec", csr_rdata, MTVEC_RST);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      quiet();
      rst_n = ($urandom_range(0, 199) != 0);
      exc = ($urandom_range(0, 9) == 0);
      exc_cause = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom}
                                              : 64'($urandom_range(0, 15));
      exc_val = {$urandom, $urandom};
      exc_pc  = {$urandom, $urandom};
      mret = ($urandom_range(0, 9) == 0);
      sret = ($urandom_range(0, 9) == 0);
      csr_we = ($urandom_range(0, 2) == 0) && !(mret || sret);
      if ($urandom_range(0, 3) == 0) csr_we = ($urandom_range(0, 1) == 1) && exc;
      csr_addr = ($urandom_range(0, 7) == 0) ? 12'($urandom)
                                             : addrs[$urandom_range(0, 9)];
      csr_wdata = {$urandom, $urandom};
      redirect_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    quiet();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
